// File: rtl/exception_ctrl.sv
// Exception entry / rte sequencer for the multicycle CPU: saves EPC, fetches the handler byte, loads PC.
// Optional cause register is built when EXC_CAUSE_REG_EN is defined.
module exception_ctrl #(
    parameter int VEC_OPCODE = 253,
    parameter int VEC_OVF    = 254,
    parameter int VEC_DIVZ   = 255,
    parameter int MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_divz,
    input  logic        ret_req,
    input  logic [31:0] pc_cur,
    input  logic [31:0] mem_data_in,
`ifdef EXC_CAUSE_REG_EN
    output logic [1:0]  cause,
`endif
    output logic        busy,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic [31:0] epc_out
);

    typedef enum logic [1:0] {IDLE, VEC_REQ, WAIT, LOAD_PC} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  vec_q, vec_d;
    logic        ret_q, ret_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic        busy_q, busy_d;
    logic        mem_rd_q, mem_rd_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        pc_load_q, pc_load_d;

    // Only the handler byte of the vector word is meaningful.
    logic unused_data_hi;
    assign unused_data_hi = ^mem_data_in[31:8];

    // Outputs are computed from the next state, so they behave as a decode of the current state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        ret_d      = ret_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        busy_d     = 1'b0;
        mem_rd_d   = 1'b0;
        mem_addr_d = 32'd0;
        pc_load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_opcode || exc_ovf || exc_divz) begin
                    epc_d = pc_cur - 32'd4;
                    ret_d = 1'b0;
                    if (exc_opcode) begin
                        vec_d   = 8'(VEC_OPCODE);
                        cause_d = 2'b01;
                    end else if (exc_ovf) begin
                        vec_d   = 8'(VEC_OVF);
                        cause_d = 2'b10;
                    end else begin
                        vec_d   = 8'(VEC_DIVZ);
                        cause_d = 2'b11;
                    end
                    state_d    = VEC_REQ;
                    busy_d     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {24'd0, vec_d};
                end else if (ret_req) begin
                    ret_d     = 1'b1;
                    state_d   = LOAD_PC;
                    pc_load_d = 1'b1;
                end
            end
            VEC_REQ: begin
                state_d = WAIT;
                cnt_d   = 3'(MEM_LAT - 1);
                busy_d  = 1'b1;
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d   = LOAD_PC;
                    pc_load_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            vec_q      <= 8'd0;
            ret_q      <= 1'b0;
            epc_q      <= 32'd0;
            cause_q    <= 2'b00;
            busy_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            pc_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            ret_q      <= ret_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            busy_q     <= busy_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            pc_load_q  <= pc_load_d;
        end
    end

    assign busy     = busy_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign pc_load  = pc_load_q;
    assign epc_out  = epc_q;
    // Handler byte is taken from memory during the load cycle itself.
    assign pc_next  = !pc_load_q ? 32'd0 : (ret_q ? epc_q : {24'd0, mem_data_in[7:0]});

`ifdef EXC_CAUSE_REG_EN
    assign cause = cause_q;
`else
    logic unused_cause;
    assign unused_cause = ^cause_q;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl (MEM_LAT = 1); pc_load events are checked against a scoreboard queue.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        reset, exc_opcode, exc_ovf, exc_divz, ret_req;
    logic [31:0] pc_cur, mem_data_in;
    logic        busy, mem_rd, pc_load;
    logic [31:0] mem_addr, pc_next, epc_out;
`ifdef EXC_CAUSE_REG_EN
    logic [1:0]  cause;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          n_loads = 0;
    logic [31:0] sb[$];

    exception_ctrl #(.VEC_OPCODE(253), .VEC_OVF(254), .VEC_DIVZ(255), .MEM_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_divz(exc_divz), .ret_req(ret_req),
        .pc_cur(pc_cur), .mem_data_in(mem_data_in),
`ifdef EXC_CAUSE_REG_EN
        .cause(cause),
`endif
        .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .pc_load(pc_load), .pc_next(pc_next), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge and any pc_load is scored.
    task automatic step();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        if (pc_load === 1'b1) begin
            n_loads++;
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL sb_unexpected_load observed pc_load=1 pc_next=%h expected no load", pc_next);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("sb_pc_next", pc_next, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; exc_opcode = 1'b0; exc_ovf = 1'b0; exc_divz = 1'b0; ret_req = 1'b0;
        pc_cur = 32'd0; mem_data_in = 32'd0;
        exc_opcode = 1'b1;
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rst_epc", epc_out, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
`ifdef EXC_CAUSE_REG_EN
        chk("rst_cause", {30'd0, cause}, 32'd0);
`endif
        exc_opcode = 1'b0;
        reset = 1'b0;
        step();

        // Overflow entry, with a divide-by-zero arriving while waiting.
        exc_ovf = 1'b1; pc_cur = 32'h40; mem_data_in = 32'h1234_56AB;
        sb.push_back(32'hAB);
        step();
        exc_ovf = 1'b0;
        chk("ovf_c1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("ovf_c1_mem_addr", mem_addr, 32'd254);
        chk("ovf_c1_busy", {31'd0, busy}, 32'd1);
        chk("ovf_epc", epc_out, 32'h3C);
        step();
        chk("ovf_c2_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("ovf_c2_mem_addr", mem_addr, 32'd0);
        chk("ovf_c2_pc_load", {31'd0, pc_load}, 32'd0);
        exc_divz = 1'b1; pc_cur = 32'h500;
        step();
        exc_divz = 1'b0;
        chk("ovf_c3_pc_load", {31'd0, pc_load}, 32'd1);
        chk("ovf_c3_pc_next", pc_next, 32'hAB);
        chk("ovf_c3_busy", {31'd0, busy}, 32'd1);
        step();
        chk("ovf_done_busy", {31'd0, busy}, 32'd0);
        chk("busy_exc_epc", epc_out, 32'h3C);
        step(); step();
        chk("busy_exc_mem_rd", {31'd0, mem_rd}, 32'd0);

        // Return from exception.
        ret_req = 1'b1;
        sb.push_back(32'h3C);
        step();
        ret_req = 1'b0;
        chk("rte_pc_load", {31'd0, pc_load}, 32'd1);
        chk("rte_pc_next", pc_next, 32'h3C);
        chk("rte_busy", {31'd0, busy}, 32'd0);
        step();
        chk("rte_after_pc_load", {31'd0, pc_load}, 32'd0);
        chk("rte_epc_kept", epc_out, 32'h3C);

        // Priority: opcode over overflow.
        exc_opcode = 1'b1; exc_ovf = 1'b1; pc_cur = 32'h100; mem_data_in = 32'hFFFF_FF10;
        sb.push_back(32'h10);
        step();
        exc_opcode = 1'b0; exc_ovf = 1'b0;
        chk("prio_mem_addr", mem_addr, 32'd253);
        chk("prio_epc", epc_out, 32'hFC);
`ifdef EXC_CAUSE_REG_EN
        chk("prio_cause", {30'd0, cause}, 32'd1);
`endif
        step(); step(); step();

        // Exception and return together: exception wins, epc wraps.
        ret_req = 1'b1; exc_divz = 1'b1; pc_cur = 32'h0; mem_data_in = 32'h0000_0077;
        sb.push_back(32'h77);
        step();
        ret_req = 1'b0; exc_divz = 1'b0;
        chk("simul_mem_addr", mem_addr, 32'd255);
        chk("simul_epc", epc_out, 32'hFFFF_FFFC);
        chk("simul_no_rte_load", {31'd0, pc_load}, 32'd0);
`ifdef EXC_CAUSE_REG_EN
        chk("simul_cause", {30'd0, cause}, 32'd3);
`endif
        step(); step();
        chk("simul_pc_next", pc_next, 32'h77);
        step();

        // Reset during WAIT abandons the sequence.
        exc_ovf = 1'b1; pc_cur = 32'h80; mem_data_in = 32'hCC;
        step();
        exc_ovf = 1'b0;
        step();
        chk("mid_rst_in_wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_epc", epc_out, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_rst_no_load", {31'd0, pc_load}, 32'd0);
        end

        chk("sb_drained", sb.size(), 32'd0);
        chk("load_count", n_loads, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
